// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for pipe_stage_buf: upstream (in_*) and downstream (out_*) sides.
// The stage itself uses the slave modport; its producer/consumer environment uses master.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry skid-buffer pipeline stage with registered in_ready, flush-to-bubble and optional
// backpressure statistics counter enabled by the PIPE_STAGE_STATS_EN macro.
module pipe_stage_buf #(
    parameter int                 DATA_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    pipe_stage_buf_if.slave       bus,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  w_main_nxt;
    logic [DATA_W-1:0]  r_skid;
    logic [DATA_W-1:0]  w_skid_nxt;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;

    // Next-state and datapath selection; flush squashes both entries regardless of handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = bus.in_data;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt  = bus.in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = BUBBLE;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    // State, entries and handshake outputs, all derived from next-state so no comb path exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= BUBBLE;
            r_skid      <= BUBBLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where downstream holds off a valid word; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf with an in-order scoreboard of accepted words.
// Statistics expectations follow the PIPE_STAGE_STATS_EN macro of the build.
module tb_pipe_stage_buf;
    localparam logic [31:0] BUB = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] stall_cnt;

    pipe_stage_buf_if #(.DATA_W(32)) bus ();

    pipe_stage_buf #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic [31:0] sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update scoreboard, return 1 time unit after the edge.
    task automatic cycle();
        logic        in_f;
        logic        out_f;
        logic [31:0] exp;
        @(negedge clk);
        in_f  = bus.in_valid & bus.in_ready;
        out_f = bus.out_valid & bus.out_ready;
        if (out_f) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed word %h expected no output", bus.out_data);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("sb_data", bus.out_data, exp);
            end
            n_out++;
        end
        if (flush) sb.delete();
        else if (in_f) sb.push_back(bus.in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int out_base;
        rst_n         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
        chk("rst_out_data",  bus.out_data,           BUB);
        chk("rst_stall_cnt", {16'h0, stall_cnt},     32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pass
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5A5_0001;
        cycle();
        bus.in_valid  = 1'b0;
        chk("single_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("single_data",  bus.out_data, 32'hA5A5_0001);
        cycle();
        chk("single_valid_after", {31'h0, bus.out_valid}, 32'h0);
        chk("single_bubble", bus.out_data, BUB);

        // Backpressure: D0, D1 accepted, D2 held upstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00D0;
        cycle();
        chk("bp_ready_one", {31'h0, bus.in_ready}, 32'h1);
        bus.in_data   = 32'h0000_00D1;
        cycle();
        chk("bp_ready_full", {31'h0, bus.in_ready}, 32'h0);
        chk("bp_data_d0", bus.out_data, 32'h0000_00D0);
        bus.in_data   = 32'h0000_00D2;
        cycle();
        chk("bp_hold_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("bp_hold_data", bus.out_data, 32'h0000_00D0);
        chk("bp_hold_ready", {31'h0, bus.in_ready}, 32'h0);
        out_base = n_out;
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_data_d1", bus.out_data, 32'h0000_00D1);
        chk("bp_ready_back", {31'h0, bus.in_ready}, 32'h1);
        cycle();
        bus.in_valid  = 1'b0;
        chk("bp_data_d2", bus.out_data, 32'h0000_00D2);
        cycle();
        chk("bp_drained_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("bp_out_count", n_out - out_base, 3);
        chk("bp_sb_empty", sb.size(), 0);

        // Streaming 100 words back-to-back
        out_base = n_out;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_data = 32'h5000_0000 + i * 32'h0001_0003;
            chk("stream_in_ready", {31'h0, bus.in_ready}, 32'h1);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("stream_out_count", n_out - out_base, 100);
        chk("stream_sb_empty", sb.size(), 0);

        // Flush in FULL with DEAD_BEEF offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00E0;
        cycle();
        bus.in_data   = 32'h0000_00E1;
        cycle();
        chk("fl_full", {31'h0, bus.in_ready}, 32'h0);
        bus.in_data   = 32'hDEAD_BEEF;
        flush         = 1'b1;
        cycle();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        chk("fl_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("fl_bubble", bus.out_data, BUB);
        chk("fl_ready", {31'h0, bus.in_ready}, 32'h1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fl_no_word", {31'h0, bus.out_valid}, 32'h0);
        end

        // Flush in ONE with an accepted DEAD_BEEF in the same cycle: must be discarded
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00F0;
        cycle();
        bus.in_data   = 32'hDEAD_BEEF;
        flush         = 1'b1;
        cycle();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("fl1_valid", {31'h0, bus.out_valid}, 32'h0);
        cycle();
        chk("fl1_no_beef", {31'h0, bus.out_valid}, 32'h0);

        // Asynchronous reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0A00;
        cycle();
        bus.in_data   = 32'h0000_0A01;
        cycle();
        chk("ar_full", {31'h0, bus.in_ready}, 32'h0);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("ar_in_ready",  {31'h0, bus.in_ready},  32'h1);
        chk("ar_out_data",  bus.out_data,           BUB);
        chk("ar_stall_cnt", {16'h0, stall_cnt},     32'h0);
        sb.delete();
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Stall statistics
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0555;
        cycle();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_five", {16'h0, stall_cnt}, 32'h0000_0005);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("stats_flush_keeps", {16'h0, stall_cnt}, 32'h0000_0006);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0666;
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        chk("stats_saturate", {16'h0, stall_cnt}, 32'h0000_FFFF);
        cycle();
        chk("stats_hold_max", {16'h0, stall_cnt}, 32'h0000_FFFF);
`else
        chk("stats_tied_zero", {16'h0, stall_cnt}, 32'h0);
`endif
        bus.out_ready = 1'b1;
        cycle();
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
